// File: rtl/half_adder_core.sv
// Lane-parallel half adder with combinational and one-cycle registered results,
// plus a saturating counter of lane carries captured on valid cycles.
module half_adder_core #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt,
    input  logic             clr_cnt
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    // One spare bit so an overflowing add is visible before clamping.
    localparam int ACC_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [ACC_W-1:0] CNT_MAX = ACC_W'({CNT_W{1'b1}});

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] carry_s;
    logic [PC_W-1:0]  pop_s;
    logic [ACC_W-1:0] acc_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] sum_q_r;
    logic [WIDTH-1:0] carry_q_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] carry_cnt_r;

    assign sum_s   = a ^ b;
    assign carry_s = a & b;
    assign pop_s   = popcount(carry_s);
    assign acc_s   = ACC_W'(carry_cnt_r) + ACC_W'(pop_s);

    // Next carry count: clear wins over accumulate, accumulate clamps at all-ones.
    always_comb begin
        cnt_nxt_s = carry_cnt_r;
        if (clr_cnt) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (in_valid) begin
            if (acc_s > CNT_MAX) begin
                cnt_nxt_s = {CNT_W{1'b1}};
            end else begin
                cnt_nxt_s = acc_s[CNT_W-1:0];
            end
        end else begin
            cnt_nxt_s = carry_cnt_r;
        end
    end

    // Result capture, valid flag and carry counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q_r     <= {WIDTH{1'b0}};
            carry_q_r   <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            carry_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (in_valid) begin
                sum_q_r   <= sum_s;
                carry_q_r <= carry_s;
            end
            out_valid_r <= in_valid;
            carry_cnt_r <= cnt_nxt_s;
        end
    end

    assign sum       = sum_s;
    assign carry     = carry_s;
    assign sum_q     = sum_q_r;
    assign carry_q   = carry_q_r;
    assign out_valid = out_valid_r;
    assign carry_cnt = carry_cnt_r;

endmodule

// File: tb/tb_half_adder_core.sv
// Directed bench for half_adder_core: three instances cover WIDTH=1, WIDTH=4
// and a narrow saturating counter (WIDTH=2, CNT_W=2).
module tb_half_adder_core;

    logic clk;
    logic rst_n;

    logic        w1_a, w1_b, w1_v, w1_clr;
    logic        w1_sum, w1_carry, w1_sum_q, w1_carry_q, w1_ov;
    logic [15:0] w1_cnt;

    logic [3:0]  w4_a, w4_b;
    logic        w4_v, w4_clr;
    logic [3:0]  w4_sum, w4_carry, w4_sum_q, w4_carry_q;
    logic        w4_ov;
    logic [15:0] w4_cnt;

    logic [1:0]  st_a, st_b;
    logic        st_v, st_clr;
    logic [1:0]  st_sum, st_carry, st_sum_q, st_carry_q;
    logic        st_ov;
    logic [1:0]  st_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    half_adder_core #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(w1_a), .b(w1_b), .in_valid(w1_v),
        .sum(w1_sum), .carry(w1_carry), .sum_q(w1_sum_q), .carry_q(w1_carry_q),
        .out_valid(w1_ov), .carry_cnt(w1_cnt), .clr_cnt(w1_clr)
    );

    half_adder_core #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(w4_a), .b(w4_b), .in_valid(w4_v),
        .sum(w4_sum), .carry(w4_carry), .sum_q(w4_sum_q), .carry_q(w4_carry_q),
        .out_valid(w4_ov), .carry_cnt(w4_cnt), .clr_cnt(w4_clr)
    );

    half_adder_core #(.WIDTH(2), .CNT_W(2)) u_st (
        .clk(clk), .rst_n(rst_n), .a(st_a), .b(st_b), .in_valid(st_v),
        .sum(st_sum), .carry(st_carry), .sum_q(st_sum_q), .carry_q(st_carry_q),
        .out_valid(st_ov), .carry_cnt(st_cnt), .clr_cnt(st_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] va = 5'b11100;  // bit i = a of vector i: 0,0,1,1,1
    logic [4:0] vb = 5'b11010;  // b: 0,1,0,1,1
    logic [4:0] es = 5'b00110;  // expected sum: 0,1,1,0,0
    logic [4:0] ec = 5'b11000;  // expected carry: 0,0,0,1,1
    int         ecnt [5] = '{0, 0, 0, 1, 2};

    initial begin
        rst_n = 1'b0;
        w1_a = 1'b0; w1_b = 1'b0; w1_v = 1'b0; w1_clr = 1'b0;
        w4_a = 4'b0000; w4_b = 4'b0000; w4_v = 1'b0; w4_clr = 1'b0;
        st_a = 2'b00; st_b = 2'b00; st_v = 1'b0; st_clr = 1'b0;

        // Reset state
        #2;
        check_eq("rst_w1_ov", 32'(w1_ov), 32'd0);
        check_eq("rst_w1_cnt", 32'(w1_cnt), 32'd0);
        check_eq("rst_w4_sumq", 32'(w4_sum_q), 32'd0);
        check_eq("rst_st_cnt", 32'(st_cnt), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // WIDTH=1 truth table through both paths
        w1_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w1_a = va[i];
            w1_b = vb[i];
            #1;
            check_eq($sformatf("w1_sum_%0d", i), 32'(w1_sum), 32'(es[i]));
            check_eq($sformatf("w1_carry_%0d", i), 32'(w1_carry), 32'(ec[i]));
            tick();
            check_eq($sformatf("w1_sumq_%0d", i), 32'(w1_sum_q), 32'(es[i]));
            check_eq($sformatf("w1_carryq_%0d", i), 32'(w1_carry_q), 32'(ec[i]));
            check_eq($sformatf("w1_ov_%0d", i), 32'(w1_ov), 32'd1);
            check_eq($sformatf("w1_cnt_%0d", i), 32'(w1_cnt), 32'(ecnt[i]));
        end

        // Build carry_cnt to 5, then reset asynchronously between edges
        for (int i = 0; i < 3; i++) tick();
        check_eq("pre_rst_cnt", 32'(w1_cnt), 32'd5);
        check_eq("pre_rst_ov", 32'(w1_ov), 32'd1);
        #2;
        rst_n = 1'b0;
        w1_a = 1'b1; w1_b = 1'b0;
        #1;
        check_eq("arst_ov", 32'(w1_ov), 32'd0);
        check_eq("arst_cnt", 32'(w1_cnt), 32'd0);
        check_eq("arst_sumq", 32'(w1_sum_q), 32'd0);
        check_eq("arst_carryq", 32'(w1_carry_q), 32'd0);
        check_eq("arst_sum_10", 32'(w1_sum), 32'd1);
        check_eq("arst_carry_10", 32'(w1_carry), 32'd0);
        w1_b = 1'b1;
        #1;
        check_eq("arst_sum_11", 32'(w1_sum), 32'd0);
        check_eq("arst_carry_11", 32'(w1_carry), 32'd1);
        w1_v = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check_eq("post_rst_ov", 32'(w1_ov), 32'd0);
        check_eq("post_rst_cnt", 32'(w1_cnt), 32'd0);

        // WIDTH=4 lanes stay independent
        w4_a = 4'b1011; w4_b = 4'b0110; w4_v = 1'b1;
        #1;
        check_eq("w4_sum", 32'(w4_sum), 32'h0000_000d);
        check_eq("w4_carry", 32'(w4_carry), 32'h0000_0002);
        tick();
        w4_v = 1'b0;
        check_eq("w4_sumq", 32'(w4_sum_q), 32'h0000_000d);
        check_eq("w4_carryq", 32'(w4_carry_q), 32'h0000_0002);
        check_eq("w4_ov", 32'(w4_ov), 32'd1);
        check_eq("w4_cnt", 32'(w4_cnt), 32'd1);

        // in_valid 1,0,1 with a=b=1; operands change during the idle cycle
        w1_a = 1'b1; w1_b = 1'b1; w1_v = 1'b1;
        tick();
        check_eq("tog1_ov", 32'(w1_ov), 32'd1);
        check_eq("tog1_carryq", 32'(w1_carry_q), 32'd1);
        check_eq("tog1_cnt", 32'(w1_cnt), 32'd1);
        w1_v = 1'b0; w1_a = 1'b0;
        tick();
        check_eq("tog2_ov", 32'(w1_ov), 32'd0);
        check_eq("tog2_sumq_hold", 32'(w1_sum_q), 32'd0);
        check_eq("tog2_carryq_hold", 32'(w1_carry_q), 32'd1);
        check_eq("tog2_cnt", 32'(w1_cnt), 32'd1);
        w1_v = 1'b1; w1_a = 1'b1;
        tick();
        w1_v = 1'b0;
        check_eq("tog3_ov", 32'(w1_ov), 32'd1);
        check_eq("tog3_cnt", 32'(w1_cnt), 32'd2);

        // Saturation on a 2-bit counter, then clear beating accumulate
        st_a = 2'b11; st_b = 2'b11; st_v = 1'b1;
        tick();
        check_eq("sat_cnt1", 32'(st_cnt), 32'd2);
        check_eq("sat_carryq", 32'(st_carry_q), 32'd3);
        check_eq("sat_sumq", 32'(st_sum_q), 32'd0);
        tick();
        check_eq("sat_cnt2", 32'(st_cnt), 32'd3);
        tick();
        check_eq("sat_cnt3", 32'(st_cnt), 32'd3);
        st_clr = 1'b1;
        tick();
        check_eq("clr_priority", 32'(st_cnt), 32'd0);
        st_clr = 1'b0; st_v = 1'b0;
        tick();
        check_eq("clr_idle", 32'(st_cnt), 32'd0);
        check_eq("clr_idle_ov", 32'(st_ov), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
